// File: rtl/tt_seq_pkg.sv
// Shared types and limits for the truth-table sequencer.
// Optional feature macro used by the top: TT_SEQ_STOP_ON_ERR_EN.
package tt_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } tt_state_e;

   localparam int N_IN_MIN   = 1;
   localparam int N_IN_MAX   = 8;
   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/tt_settle_cnt.sv
// Settle down-counter. 'zero' flags the final settle cycle, so the FSM
// leaves SETTLE on the edge where the count reaches zero.
module tt_settle_cnt
   import tt_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (load)       cnt <= val;
      else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
   end

   assign zero = (cnt[CNT_W-1:1] == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input combination of a combinational DUT, captures its output
// per row and counts mismatches. Define TT_SEQ_STOP_ON_ERR_EN to stop on first mismatch.
module truth_table_sequencer
   import tt_seq_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [(1<<N_IN)-1:0] exp_table,
   input  logic                 dut_s,
   output logic [N_IN-1:0]      vec_o,
   output logic                 row_valid,
   output logic                 row_s,
   output logic                 mismatch,
   output logic [N_IN:0]        err_cnt,
   output logic                 busy,
   output logic                 done
);

   localparam logic [N_IN-1:0]  LAST_ROW = '1;
   localparam logic [N_IN:0]    ERR_MAX  = (N_IN+1)'(1 << N_IN);
   localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

   tt_state_e state, state_nxt;
   logic      accept, capture, cnt_load, cnt_zero, miss_now, stop_now;

   assign miss_now = (dut_s != exp_table[vec_o]);

`ifdef TT_SEQ_STOP_ON_ERR_EN
   assign stop_now = (vec_o == LAST_ROW) || miss_now;
`else
   assign stop_now = (vec_o == LAST_ROW);
`endif

   tt_settle_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .val   (SETTLE_V),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start)    state_nxt = S_SETTLE;
         S_SETTLE:  if (cnt_zero) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = stop_now ? S_DONE : S_SETTLE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      accept   = (state == S_IDLE) && start;
      capture  = (state == S_CAPTURE);
      cnt_load = accept || (capture && !stop_now);
   end

   // Row results are registered on the capture edge, so they appear the cycle after CAPTURE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_o     <= '0;
         row_valid <= 1'b0;
         row_s     <= 1'b0;
         mismatch  <= 1'b0;
         err_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         row_valid <= capture;
         mismatch  <= capture && miss_now;
         done      <= (state == S_DONE);
         if (capture) row_s <= dut_s;
         if (accept) begin
            vec_o   <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
         end
         if (capture) begin
            if (miss_now && err_cnt != ERR_MAX) err_cnt <= err_cnt + (N_IN+1)'(1);
            if (!stop_now) vec_o <= vec_o + N_IN'(1);
         end
         if (state == S_DONE) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a 2-input/SETTLE=1 and a 3-input/SETTLE=3
// instance, each driven by a table-defined DUT function, checked against a row-latency model.
module tb_truth_table_sequencer;

`ifdef TT_SEQ_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, start;
   int   sel;
   int   passes = 0;
   int   total  = 0;

   logic [3:0] fn2, ex2;
   logic [7:0] fn3, ex3;
   logic [1:0] vec2;
   logic [2:0] vec3, err2;
   logic [3:0] err3;
   logic rv2, rs2, mm2, bz2, dn2, rv3, rs3, mm3, bz3, dn3;
   logic rv_m, rs_m, mm_m, bz_m, dn_m;
   logic [31:0] vec_m, err_m;

   always #5 clk = ~clk;

   truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .exp_table(ex2),
      .dut_s(fn2[vec2]), .vec_o(vec2), .row_valid(rv2), .row_s(rs2),
      .mismatch(mm2), .err_cnt(err2), .busy(bz2), .done(dn2));

   truth_table_sequencer #(.N_IN(3), .SETTLE(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .exp_table(ex3),
      .dut_s(fn3[vec3]), .vec_o(vec3), .row_valid(rv3), .row_s(rs3),
      .mismatch(mm3), .err_cnt(err3), .busy(bz3), .done(dn3));

   assign rv_m  = (sel == 1) ? rv3 : rv2;
   assign rs_m  = (sel == 1) ? rs3 : rs2;
   assign mm_m  = (sel == 1) ? mm3 : mm2;
   assign bz_m  = (sel == 1) ? bz3 : bz2;
   assign dn_m  = (sel == 1) ? dn3 : dn2;
   assign vec_m = (sel == 1) ? 32'(vec3) : 32'(vec2);
   assign err_m = (sel == 1) ? 32'(err3) : 32'(err2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h (sel=%0d)", tag, obs, exp, sel);
   endtask

   // Row r is reported r*(SETTLE+1)+SETTLE+1 cycles after acceptance; done one cycle after the last row.
   task automatic sweep(input int s, input logic [7:0] fn, input logic [7:0] ex,
                        input bit hold, input bit chg);
      int nin, st, rows, r, errs, done_k, lim;
      bit fin, mm;
      logic [7:0] ex_cap;
      nin = (s == 1) ? 3 : 2;
      st  = (s == 1) ? 3 : 1;
      rows = 1 << nin;
      sel = s; fn2 = fn[3:0]; fn3 = fn; ex2 = ex[3:0]; ex3 = ex;
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("accept_busy", 32'(bz_m), 32'd1);
      chk("accept_vec", vec_m, 32'd0);
      chk("accept_err", err_m, 32'd0);
      r = 0; errs = 0; fin = 1'b0; done_k = -1; lim = rows * (st + 1) + 4;
      for (int k = 1; k <= lim && !(fin && k > done_k); k++) begin
         if (chg && k == st + 2) begin
            ex2 = 4'($urandom);
            ex3 = 8'($urandom);
         end
         ex_cap = (s == 1) ? ex3 : {4'h0, ex2};
         @(negedge clk);
         if (!fin && k == r * (st + 1) + st + 1) begin
            chk("row_valid", 32'(rv_m), 32'd1);
            mm = (fn[r] != ex_cap[r]);
            chk("row_s", 32'(rs_m), 32'(fn[r]));
            chk("mismatch", 32'(mm_m), 32'(mm));
            errs += int'(mm);
            r++;
            if (r == rows || (STOP && mm)) begin
               fin = 1'b1;
               done_k = k + 1;
            end
         end else begin
            chk("row_valid_low", 32'(rv_m), 32'd0);
         end
         if (k == done_k) begin
            chk("done", 32'(dn_m), 32'd1);
            chk("done_busy", 32'(bz_m), 32'd0);
            chk("done_err", err_m, 32'(errs));
            chk("done_vec", vec_m, 32'(r - 1));
         end else begin
            chk("done_low", 32'(dn_m), 32'd0);
            chk("busy_high", 32'(bz_m), 32'd1);
         end
      end
      if (hold) begin
         @(negedge clk);
         chk("restart_busy", 32'(bz_m), 32'd1);
         chk("restart_vec", vec_m, 32'd0);
         chk("restart_done", 32'(dn_m), 32'd0);
         start = 1'b0;
         repeat (rows * (st + 1) + 3) @(negedge clk);
         chk("restart_idle", 32'(bz_m), 32'd0);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sel = 0;
      fn2 = 4'h2; ex2 = 4'h2; fn3 = 8'hFF; ex3 = 8'hFF;
      repeat (2) @(negedge clk);
      chk("rst_vec", vec_m, 32'd0);
      chk("rst_busy", 32'(bz_m), 32'd0);
      chk("rst_err", err_m, 32'd0);
      chk("rst_rv", 32'(rv_m), 32'd0);
      chk("rst_done", 32'(dn_m), 32'd0);
      chk("rst_vec3", 32'(vec3), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      sweep(0, 8'h02, 8'h02, 1'b0, 1'b0);   // s = ~a&b, all rows match
      sweep(0, 8'h02, 8'h08, 1'b0, 1'b0);   // mismatches on rows 1 and 3
      sweep(0, 8'h02, 8'h00, 1'b0, 1'b0);   // single mismatch on row 1
      sweep(1, 8'hFF, 8'hFF, 1'b0, 1'b0);   // 3-input, SETTLE=3

      // Abort during the settle phase of row 2.
      sel = 0; fn2 = 4'h2; ex2 = 4'h2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_vec", vec_m, 32'd0);
      chk("abort_busy", 32'(bz_m), 32'd0);
      chk("abort_err", err_m, 32'd0);
      chk("abort_rs", 32'(rs_m), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(dn_m), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle_done", 32'(dn_m), 32'd0);
      sweep(0, 8'h02, 8'h02, 1'b0, 1'b0);

      sweep(0, 8'h02, 8'h02, 1'b1, 1'b0);   // start held through the sweep
      sweep(1, 8'hA5, 8'h3C, 1'b1, 1'b0);

      for (int i = 0; i < 8; i++)
         sweep(i % 2, 8'($urandom), 8'($urandom), 1'b0, 1'($urandom));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
